// File: rtl/sctag_vuad_pkg.sv
// Shared widths and helpers for the VUAD diagnostic/BIST datapath.
// The swizzle works on a wide fixed-size word so that it can serve any DW up to DW_MAX.
package sctag_vuad_pkg;

    localparam int DW_DEF = 26;
    localparam int PW_DEF = 4;
    localparam int BW_DEF = 8;
    localparam int DW_MAX = 64;

    function automatic int gw_of(input int dw, input int pw);
        return (dw + pw - 1) / pw;
    endfunction

    // S(d) = {d[dw-1], d[dw-3:h], d[dw-2], d[h-1:0]} with h = (dw-2)/2
    function automatic logic [DW_MAX-1:0] swizzle(input logic [DW_MAX-1:0] d, input int dw);
        int h;
        logic [DW_MAX-1:0] one;
        logic [DW_MAX-1:0] lo_m;
        logic [DW_MAX-1:0] mid_m;
        logic [DW_MAX-1:0] o;
        h     = (dw - 2) / 2;
        one   = DW_MAX'(1);
        lo_m  = (one << h) - one;
        mid_m = (one << (dw - 2 - h)) - one;
        o     = d & lo_m;
        o     = o | (((d >> (dw - 2)) & one) << h);
        o     = o | (((d >> h) & mid_m) << (h + 1));
        o     = o | (((d >> (dw - 1)) & one) << (dw - 1));
        return o;
    endfunction

endpackage

// File: rtl/sctag_vuad_diag_if.sv
// Bus bundle for the VUAD diagnostic pipe: array read/write data, BIST controls and results.
interface sctag_vuad_diag_if
    import sctag_vuad_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int PW    = PW_DEF,
    parameter int BW    = BW_DEF,
    parameter int CNT_W = 8
) ();

    logic             acc_ua_c2;
    logic [DW-1:0]    rd_ua_data_c2;
    logic [DW-1:0]    rd_vd_data_c2;
    logic             rd_vld_c2;
    logic [PW-1:0]    rd_parity_c2;
    logic [DW-1:0]    wr_data_c2;
    logic [BW-1:0]    bist_data_in;
    logic             bist_ld;
    logic             bist_rot;
    logic             sel_diag_ua_c3;
    logic             sel_diag_vd_c3;
    logic             err_clr;
    logic [DW-1:0]    diag_data_out;
    logic             diag_vld_out;
    logic [PW-1:0]    parity_tap;
    logic [PW-1:0]    syndrome_out;
    logic             par_err_out;
    logic [CNT_W-1:0] err_cnt;
    logic [DW-1:0]    ua_wr_data;
    logic [DW-1:0]    vd_wr_data;

    modport master (
        output acc_ua_c2, rd_ua_data_c2, rd_vd_data_c2, rd_vld_c2, rd_parity_c2,
               wr_data_c2, bist_data_in, bist_ld, bist_rot,
               sel_diag_ua_c3, sel_diag_vd_c3, err_clr,
        input  diag_data_out, diag_vld_out, parity_tap, syndrome_out,
               par_err_out, err_cnt, ua_wr_data, vd_wr_data
    );

    modport slave (
        input  acc_ua_c2, rd_ua_data_c2, rd_vd_data_c2, rd_vld_c2, rd_parity_c2,
               wr_data_c2, bist_data_in, bist_ld, bist_rot,
               sel_diag_ua_c3, sel_diag_vd_c3, err_clr,
        output diag_data_out, diag_vld_out, parity_tap, syndrome_out,
               par_err_out, err_cnt, ua_wr_data, vd_wr_data
    );

endinterface

// File: rtl/sctag_vuad_par_chk.sv
// Combinational even-parity syndrome: one bit per group, last group truncated to fit DW.
module sctag_vuad_par_chk
    import sctag_vuad_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic [DW-1:0] data,
    input  logic [PW-1:0] parity,
    output logic [PW-1:0] syn
);

    localparam int GW = gw_of(DW, PW);

    for (genvar g = 0; g < PW; g++) begin : g_grp
        localparam int LO = g * GW;
        localparam int HI = (LO + GW > DW) ? DW - 1 : LO + GW - 1;
        // Rounding up GW can leave trailing groups with no data bits
        if (LO < DW) begin : g_data
            assign syn[g] = (^data[HI:LO]) ^ parity[g];
        end else begin : g_empty
            assign syn[g] = parity[g];
        end
    end

endmodule

// File: rtl/sctag_vuad_diag_pipe.sv
// VUAD diagnostic read pipe with parity check and error count, plus the registered
// diagnostic/BIST write data for the UA and VD arrays.
module sctag_vuad_diag_pipe
    import sctag_vuad_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int PW       = PW_DEF,
    parameter int BW       = BW_DEF,
    parameter int DIAG_LAT = 6,
    parameter int PAR_TAP  = 2,
    parameter int CNT_W    = 8
) (
    input logic               rclk,
    input logic               reset,
    sctag_vuad_diag_if.slave  bus
);

    logic [DIAG_LAT-1:0][DW-1:0] pipe_data_q, pipe_data_d;
    logic [DIAG_LAT-1:0][PW-1:0] pipe_par_q, pipe_par_d;
    logic [DIAG_LAT-1:0]         pipe_vld_q, pipe_vld_d;
    logic [PW-1:0]               syn_raw;
    logic [PW-1:0]               syn_q, syn_d;
    logic                        par_err_q, par_err_d;
    logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
    logic [BW-1:0]               pat_q, pat_d;
    logic [DW-1:0]               rep;
    logic [DW-1:0]               wr_data_c3_q, wr_data_c3_d;
    logic [DW-1:0]               ua_wr_q, ua_wr_d;
    logic [DW-1:0]               vd_wr_q, vd_wr_d;
    logic [DW-1:0]               rd_sel;

    sctag_vuad_par_chk #(
        .DW (DW),
        .PW (PW)
    ) u_par_chk (
        .data   (pipe_data_q[DIAG_LAT-1]),
        .parity (pipe_par_q[DIAG_LAT-1]),
        .syn    (syn_raw)
    );

    for (genvar i = 0; i < DW; i++) begin : g_rep
        assign rep[i] = pat_q[i % BW];
    end

    always_comb begin
        rd_sel       = bus.acc_ua_c2 ? bus.rd_ua_data_c2 : bus.rd_vd_data_c2;
        pipe_data_d  = {pipe_data_q[DIAG_LAT-2:0], rd_sel};
        pipe_par_d   = {pipe_par_q[DIAG_LAT-2:0], bus.rd_parity_c2};
        pipe_vld_d   = {pipe_vld_q[DIAG_LAT-2:0], bus.rd_vld_c2};

        syn_d        = pipe_vld_q[DIAG_LAT-1] ? syn_raw : '0;
        par_err_d    = pipe_vld_q[DIAG_LAT-1] & (|syn_raw);

        // A clear coinciding with a new error restarts the count at one, not zero
        err_cnt_d    = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = par_err_d ? CNT_W'(1) : '0;
        end else if (par_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        pat_d        = pat_q;
        if (bus.bist_ld) begin
            pat_d = bus.bist_data_in;
        end else if (bus.bist_rot) begin
            pat_d = {pat_q[BW-2:0], pat_q[BW-1]};
        end

        // Write data uses the pattern as it stands before this edge's load/rotate
        wr_data_c3_d = bus.wr_data_c2;
        ua_wr_d      = DW'(swizzle(DW_MAX'(bus.sel_diag_ua_c3 ? wr_data_c3_q : rep), DW));
        vd_wr_d      = DW'(swizzle(DW_MAX'(bus.sel_diag_vd_c3 ? wr_data_c3_q : rep), DW));
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            pipe_data_q  <= '0;
            pipe_par_q   <= '0;
            pipe_vld_q   <= '0;
            syn_q        <= '0;
            par_err_q    <= 1'b0;
            err_cnt_q    <= '0;
            pat_q        <= '0;
            wr_data_c3_q <= '0;
            ua_wr_q      <= '0;
            vd_wr_q      <= '0;
        end else begin
            pipe_data_q  <= pipe_data_d;
            pipe_par_q   <= pipe_par_d;
            pipe_vld_q   <= pipe_vld_d;
            syn_q        <= syn_d;
            par_err_q    <= par_err_d;
            err_cnt_q    <= err_cnt_d;
            pat_q        <= pat_d;
            wr_data_c3_q <= wr_data_c3_d;
            ua_wr_q      <= ua_wr_d;
            vd_wr_q      <= vd_wr_d;
        end
    end

    assign bus.diag_data_out = pipe_data_q[DIAG_LAT-1];
    assign bus.diag_vld_out  = pipe_vld_q[DIAG_LAT-1];
    assign bus.parity_tap    = pipe_par_q[PAR_TAP-1];
    assign bus.syndrome_out  = syn_q;
    assign bus.par_err_out   = par_err_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.ua_wr_data    = ua_wr_q;
    assign bus.vd_wr_data    = vd_wr_q;

endmodule

// File: tb/tb_sctag_vuad_diag_pipe.sv
// Directed bench for sctag_vuad_diag_pipe; expected values are worked out by hand
// (group parity of 26'h2AAAAAA with GW=7 is 4'b1101).
module tb_sctag_vuad_diag_pipe;

    logic rclk  = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic seen_err;

    sctag_vuad_diag_if #(.DW(26), .PW(4), .BW(8), .CNT_W(8)) bus_if ();

    sctag_vuad_diag_pipe #(
        .DW       (26),
        .PW       (4),
        .BW       (8),
        .DIAG_LAT (6),
        .PAR_TAP  (2),
        .CNT_W    (8)
    ) dut (
        .rclk  (rclk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.acc_ua_c2      = 1'b0;
        bus_if.rd_ua_data_c2  = '0;
        bus_if.rd_vd_data_c2  = '0;
        bus_if.rd_vld_c2      = 1'b0;
        bus_if.rd_parity_c2   = '0;
        bus_if.wr_data_c2     = '0;
        bus_if.bist_data_in   = '0;
        bus_if.bist_ld        = 1'b0;
        bus_if.bist_rot       = 1'b0;
        bus_if.sel_diag_ua_c3 = 1'b0;
        bus_if.sel_diag_vd_c3 = 1'b0;
        bus_if.err_clr        = 1'b0;
    endtask

    task automatic send_rd(input logic ua, input logic [25:0] data, input logic [3:0] par);
        bus_if.acc_ua_c2     = ua;
        bus_if.rd_ua_data_c2 = ua ? data : ~data;
        bus_if.rd_vd_data_c2 = ua ? ~data : data;
        bus_if.rd_vld_c2     = 1'b1;
        bus_if.rd_parity_c2  = par;
        tick(1);
        bus_if.rd_vld_c2     = 1'b0;
        bus_if.rd_parity_c2  = '0;
        bus_if.rd_ua_data_c2 = '0;
        bus_if.rd_vd_data_c2 = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(2);
        check("rst_data",  32'(bus_if.diag_data_out), 32'h0);
        check("rst_vld",   32'(bus_if.diag_vld_out),  32'h0);
        check("rst_tap",   32'(bus_if.parity_tap),    32'h0);
        check("rst_syn",   32'(bus_if.syndrome_out),  32'h0);
        check("rst_err",   32'(bus_if.par_err_out),   32'h0);
        check("rst_cnt",   32'(bus_if.err_cnt),       32'h0);
        check("rst_ua",    32'(bus_if.ua_wr_data),    32'h0);
        check("rst_vd",    32'(bus_if.vd_wr_data),    32'h0);
        reset = 1'b0;
        tick(1);

        // clean UA read
        send_rd(1'b1, 26'h2AAAAAA, 4'b1101);
        tick(1);
        check("t1_tap",     32'(bus_if.parity_tap),    32'hD);
        tick(3);
        check("t1_vld_early", 32'(bus_if.diag_vld_out), 32'h0);
        tick(1);
        check("t1_data",    32'(bus_if.diag_data_out), 32'h2AAAAAA);
        check("t1_vld",     32'(bus_if.diag_vld_out),  32'h1);
        tick(1);
        check("t1_syn",     32'(bus_if.syndrome_out),  32'h0);
        check("t1_err",     32'(bus_if.par_err_out),   32'h0);
        check("t1_cnt",     32'(bus_if.err_cnt),       32'h0);

        // clean VD read, UA bus carries the inverse
        send_rd(1'b0, 26'h0000081, 4'b0011);
        tick(5);
        check("t1b_data",   32'(bus_if.diag_data_out), 32'h0000081);
        tick(1);
        check("t1b_err",    32'(bus_if.par_err_out),   32'h0);

        // parity bit 3 flipped
        send_rd(1'b1, 26'h2AAAAAA, 4'b0101);
        tick(5);
        check("t2_err_early", 32'(bus_if.par_err_out), 32'h0);
        tick(1);
        check("t2_syn",     32'(bus_if.syndrome_out),  32'h8);
        check("t2_err",     32'(bus_if.par_err_out),   32'h1);
        check("t2_cnt",     32'(bus_if.err_cnt),       32'h1);
        tick(1);
        check("t2_err_late", 32'(bus_if.par_err_out),  32'h0);
        check("t2_syn_late", 32'(bus_if.syndrome_out), 32'h0);

        // 300 back-to-back errors, count starts at 1
        bus_if.acc_ua_c2     = 1'b1;
        bus_if.rd_ua_data_c2 = 26'h2AAAAAA;
        bus_if.rd_parity_c2  = 4'b0101;
        bus_if.rd_vld_c2     = 1'b1;
        tick(10);
        check("t3_cnt_mid", 32'(bus_if.err_cnt),       32'h5);
        tick(290);
        idle_inputs();
        tick(7);
        check("t3_cnt_sat", 32'(bus_if.err_cnt),       32'hFF);
        tick(5);
        check("t3_cnt_hold", 32'(bus_if.err_cnt),      32'hFF);
        send_rd(1'b1, 26'h2AAAAAA, 4'b0101);
        tick(5);
        bus_if.err_clr = 1'b1;
        tick(1);
        bus_if.err_clr = 1'b0;
        check("t3_clr_inc", 32'(bus_if.err_cnt),       32'h1);
        bus_if.err_clr = 1'b1;
        tick(1);
        bus_if.err_clr = 1'b0;
        check("t3_clr",     32'(bus_if.err_cnt),       32'h0);

        // BIST load then rotate
        bus_if.bist_data_in = 8'h81;
        bus_if.bist_ld      = 1'b1;
        tick(1);
        bus_if.bist_ld      = 1'b0;
        bus_if.bist_rot     = 1'b1;
        tick(1);
        bus_if.bist_rot     = 1'b0;
        check("t4_ua_81",   32'(bus_if.ua_wr_data),    32'h1031181);
        check("t4_pat",     32'(dut.pat_q),            32'h03);
        tick(1);
        check("t4_ua_03",   32'(bus_if.ua_wr_data),    32'h2061303);
        check("t4_vd_03",   32'(bus_if.vd_wr_data),    32'h2061303);
        bus_if.bist_data_in = 8'h5A;
        bus_if.bist_ld      = 1'b1;
        bus_if.bist_rot     = 1'b1;
        tick(1);
        bus_if.bist_ld      = 1'b0;
        bus_if.bist_rot     = 1'b0;
        check("t4_ld_prio", 32'(dut.pat_q),            32'h5A);

        // diag write swizzle
        bus_if.sel_diag_vd_c3 = 1'b1;
        bus_if.sel_diag_ua_c3 = 1'b1;
        bus_if.wr_data_c2     = 26'h1000000;
        tick(1);
        bus_if.wr_data_c2     = 26'h0001000;
        tick(1);
        bus_if.wr_data_c2     = '0;
        check("t5_vd_b24",  32'(bus_if.vd_wr_data),    32'h0001000);
        check("t5_ua_b24",  32'(bus_if.ua_wr_data),    32'h0001000);
        tick(1);
        check("t5_vd_b12",  32'(bus_if.vd_wr_data),    32'h0002000);
        bus_if.sel_diag_vd_c3 = 1'b0;
        bus_if.sel_diag_ua_c3 = 1'b0;
        tick(1);

        // reset with reads in flight
        send_rd(1'b1, 26'h2AAAAAA, 4'b0101);
        tick(6);
        check("t6_cnt_pre", 32'(bus_if.err_cnt),       32'h1);
        bus_if.acc_ua_c2     = 1'b1;
        bus_if.rd_ua_data_c2 = 26'h2AAAAAA;
        bus_if.rd_parity_c2  = 4'b0101;
        bus_if.rd_vld_c2     = 1'b1;
        tick(3);
        idle_inputs();
        tick(1);
        reset = 1'b1;
        #1;
        check("t6_rst_cnt", 32'(bus_if.err_cnt),       32'h0);
        check("t6_rst_ua",  32'(bus_if.ua_wr_data),    32'h0);
        check("t6_rst_tap", 32'(bus_if.parity_tap),    32'h0);
        check("t6_rst_pat", 32'(dut.pat_q),            32'h0);
        tick(1);
        reset = 1'b0;
        seen_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus_if.par_err_out !== 1'b0 || bus_if.diag_vld_out !== 1'b0) seen_err = 1'b1;
        end
        check("t6_no_err",  32'(seen_err),             32'h0);
        check("t6_cnt",     32'(bus_if.err_cnt),       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
